axon_input_packer: RTL and testbench

AXON_INPUT_PACKER -- requirements
Module: axon_input_packer

---
 rtl/axon_input_packer.sv | 164 ++++++++++++++++
 tb/tb_axon_input_packer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axon_input_packer.sv
// axon_input_packer: gathers 16 consecutive BRAM words, addressed by an
// external address counter, into one wide beat and offers it on a
// valid/ready output. Runs until the beat holding the terminal word is taken.

// One output lane: a DATA_WIDTH register loaded when its write strobe fires.
module axon_packer_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] q_q;

  // Lane storage; holds its value between beats and after the run ends.
  always_ff @(posedge clk) begin
    if (!rst)      q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

module axon_input_packer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_LENGTH = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDRESS_LENGTH-1:0]  addr_in,
  input  logic                       flag_1per16,
  input  logic                       cnt_done,
  output logic                       cnt_en,
  output logic [ADDRESS_LENGTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic [16*DATA_WIDTH-1:0]   m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic                       busy,
  output logic                       done
);

  // Beat width is tied to the counter's 1-per-16 flag, so it is fixed.
  localparam int WORDS_PER_BEAT = 16;
  localparam int LANE_W         = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_OUT,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  // Pending read: the address issued this cycle returns data next cycle,
  // so its lane and markers ride one stage behind the counter.
  logic              pend_vld_q, pend_vld_d;
  logic [LANE_W-1:0] pend_lane_q, pend_lane_d;
  logic              pend_last_q, pend_last_d;
  logic              pend_term_q, pend_term_d;
  logic              m_last_q, m_last_d;

  logic [WORDS_PER_BEAT-1:0]                 lane_we;
  logic [WORDS_PER_BEAT-1:0][DATA_WIDTH-1:0] lane_q;

  // State and pending-read registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pend_vld_q  <= 1'b0;
      pend_lane_q <= '0;
      pend_last_q <= 1'b0;
      pend_term_q <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_lane_q <= pend_lane_d;
      pend_last_q <= pend_last_d;
      pend_term_q <= pend_term_d;
      m_last_q    <= m_last_d;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    m_valid = 1'b0;
    done    = 1'b0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        // A run already parked on the terminal address has nothing to send.
        if (start && !cnt_done) state_d = S_FILL;
      end
      S_FILL: begin
        cnt_en = 1'b1;
        // Stop issuing after the 16th word; the counter then rests on the
        // next aligned address (or stays on the terminal one).
        if (flag_1per16) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = m_last_q ? S_FINISH : S_FILL;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every FILL cycle launches one read; nothing is in flight otherwise.
  always_comb begin
    pend_vld_d  = (state_q == S_FILL);
    pend_lane_d = addr_in[LANE_W-1:0];
    pend_last_d = flag_1per16;
    pend_term_d = cnt_done;
  end

  // m_last follows the terminal marker of the beat's final word, which lands
  // during DRAIN; it is otherwise held so it stays stable through OUT/IDLE.
  always_comb begin
    m_last_d = m_last_q;
    if (pend_vld_q && pend_last_q) m_last_d = pend_term_q;
  end

  // Steer the returning word into its lane.
  always_comb begin
    for (int k = 0; k < WORDS_PER_BEAT; k++)
      lane_we[k] = pend_vld_q && (pend_lane_q == LANE_W'(k));
  end

  genvar g;
  generate
    for (g = 0; g < WORDS_PER_BEAT; g++) begin : g_lane
      axon_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .we_i (lane_we[g]),
        .d_i  (mem_rdata),
        .q_o  (lane_q[g])
      );
    end
  endgenerate

  assign mem_addr = addr_in;
  assign m_data   = lane_q;
  assign m_last   = m_last_q;

endmodule

// File: tb/tb_axon_input_packer.sv
// Bench for axon_input_packer with a 512-word address counter and a BRAM
// model whose read data is the registered address.
module tb_axon_input_packer;

  localparam int DW = 16;
  localparam int AL = 13;
  localparam int MAX_COUNT = 512;
  localparam int BEATS = MAX_COUNT / 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [AL-1:0]  addr_in;
  logic           flag_1per16, cnt_done, cnt_en;
  logic [AL-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata;
  logic [16*DW-1:0] m_data;
  logic           m_valid, m_last, busy, done;
  logic           m_ready = 1'b1;

  int total = 0;
  int bad = 0;

  logic [16*DW-1:0] beat_q[$];
  logic             last_q[$];
  int               done_cnt = 0;

  always #5 clk = ~clk;

  axon_input_packer #(.DATA_WIDTH(DW), .ADDRESS_LENGTH(AL)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_in(addr_in),
    .flag_1per16(flag_1per16), .cnt_done(cnt_done), .cnt_en(cnt_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  // Upstream counter: 0..MAX_COUNT-1, holds at terminal.
  always @(posedge clk) begin
    if (!rst) addr_in <= '0;
    else if (cnt_en && addr_in != AL'(MAX_COUNT-1)) addr_in <= addr_in + 1'b1;
  end
  assign flag_1per16 = (addr_in[3:0] == 4'hF);
  assign cnt_done    = (addr_in == AL'(MAX_COUNT-1));

  // BRAM model: one-cycle read latency, data = address.
  always @(posedge clk) mem_rdata <= DW'(mem_addr);

  // Record accepted beats and done pulses away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (m_valid && m_ready) begin
        beat_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [16*DW-1:0] exp_beat(input int n);
    logic [16*DW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*DW +: DW] = DW'(16*n + k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; m_ready = 1'b1; rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int dbase, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_cnt > dbase) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    total++;
    if ({cnt_en, m_valid, m_last, busy, done} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got %b want 00000", {cnt_en, m_valid, m_last, busy, done});
    end
    total++;
    if (m_data !== '0 || mem_addr !== '0) begin
      bad++; $display("FAIL reset_data got m_data=%h mem_addr=%0d want 0", m_data, mem_addr);
    end
  endtask

  task automatic test_latency();
    do_reset();
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      total++;
      if (cnt_en !== 1'b1) begin
        bad++; $display("FAIL latency_cnt_en cycle %0d got %b want 1", c, cnt_en);
      end
      tick();
    end
    total++;
    if (cnt_en !== 1'b0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL latency_c17 got cnt_en=%b m_valid=%b want 0 0", cnt_en, m_valid);
    end
    tick();
    total++;
    if (m_valid !== 1'b1 || m_data !== exp_beat(0)) begin
      bad++; $display("FAIL latency_c18 got m_valid=%b data=%h want 1 %h", m_valid, m_data, exp_beat(0));
    end
  endtask

  task automatic test_full_run();
    int b, d;
    bit ok;
    do_reset();
    b = beat_q.size(); d = done_cnt;
    pulse_start();
    wait_done(d, 2000, ok);
    repeat (5) tick();
    total++;
    if (!ok) begin bad++; $display("FAIL full_timeout got no done want done"); end
    total++;
    if (beat_q.size() - b != BEATS) begin
      bad++; $display("FAIL full_count got %0d want %0d", beat_q.size() - b, BEATS);
    end
    for (int i = 0; i < BEATS && b + i < beat_q.size(); i++) begin
      total++;
      if (beat_q[b+i] !== exp_beat(i) || last_q[b+i] !== (i == BEATS-1)) begin
        bad++; $display("FAIL full_beat%0d got %h last=%b want %h last=%b",
                        i, beat_q[b+i], last_q[b+i], exp_beat(i), (i == BEATS-1));
      end
    end
    total++;
    if (done_cnt - d != 1 || addr_in !== AL'(511) || busy !== 1'b0) begin
      bad++; $display("FAIL full_end got done=%0d addr=%0d busy=%b want 1 511 0", done_cnt - d, addr_in, busy);
    end
  endtask

  task automatic test_backpressure();
    int b, d;
    bit ok;
    do_reset();
    b = beat_q.size(); d = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_valid && beat_q.size() - b == 3) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL bp_reach_beat3 got timeout want beat 3 valid"); end
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== exp_beat(3) || m_last !== 1'b0 ||
          cnt_en !== 1'b0 || addr_in !== AL'(64)) begin
        bad++; $display("FAIL bp_hold cycle %0d got v=%b last=%b en=%b addr=%0d data=%h want 1 0 0 64 %h",
                        c, m_valid, m_last, cnt_en, addr_in, m_data, exp_beat(3));
      end
      tick();
    end
    m_ready = 1'b1;
    wait_done(d, 2000, ok);
    repeat (3) tick();
    total++;
    if (!ok || beat_q.size() - b != BEATS) begin
      bad++; $display("FAIL bp_count got %0d done=%b want %0d", beat_q.size() - b, ok, BEATS);
    end
    total++;
    if (b + 4 >= beat_q.size() || beat_q[b+4] !== exp_beat(4)) begin
      bad++; $display("FAIL bp_beat4 got missing-or-wrong want %h", exp_beat(4));
    end
  endtask

  task automatic test_start_ignored();
    int b, d;
    bit ok;
    bit busy_bad;
    do_reset();
    b = beat_q.size(); d = done_cnt;
    pulse_start();
    ok = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt > d) begin ok = 1'b1; break; end
      if (busy !== 1'b1) busy_bad = 1'b1;
      start = (i % 7 == 3);
      tick();
    end
    start = 1'b0;
    total++;
    if (!ok || busy_bad) begin
      bad++; $display("FAIL ign_run got done=%b busy_drop=%b want 1 0", ok, busy_bad);
    end
    repeat (3) tick();
    pulse_start();
    repeat (40) tick();
    total++;
    if (beat_q.size() - b != BEATS || done_cnt - d != 1) begin
      bad++; $display("FAIL ign_extra got beats=%0d done=%0d want %0d 1", beat_q.size() - b, done_cnt - d, BEATS);
    end
    total++;
    if (busy !== 1'b0 || cnt_en !== 1'b0) begin
      bad++; $display("FAIL ign_idle got busy=%b cnt_en=%b want 0 0", busy, cnt_en);
    end
  endtask

  task automatic test_mid_reset();
    int b, nb, nd;
    bit ok;
    do_reset();
    b = beat_q.size();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_valid && beat_q.size() - b == 5) begin ok = 1'b1; break; end
      tick();
    end
    m_ready = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL mrst_reach_beat5 got timeout want beat 5 valid"); end
    rst = 1'b0;
    tick();
    total++;
    if ({cnt_en, m_valid, m_last, busy, done} !== 5'b0 || m_data !== '0) begin
      bad++; $display("FAIL mrst_outputs got ctrl=%b data=%h want 00000 0",
                      {cnt_en, m_valid, m_last, busy, done}, m_data);
    end
    tick();
    rst = 1'b1;
    m_ready = 1'b1;
    nb = beat_q.size(); nd = done_cnt;
    repeat (30) tick();
    total++;
    if (beat_q.size() != nb || done_cnt != nd) begin
      bad++; $display("FAIL mrst_quiet got beats=%0d done=%0d want 0 0", beat_q.size() - nb, done_cnt - nd);
    end
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (beat_q.size() > nb) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok || beat_q[nb] !== exp_beat(0) || last_q[nb] !== 1'b0) begin
      bad++; $display("FAIL mrst_restart got ok=%b want beat %h", ok, exp_beat(0));
    end
  endtask

  task automatic test_random_ready();
    int b, d;
    bit ok;
    do_reset();
    b = beat_q.size(); d = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (done_cnt > d) begin ok = 1'b1; break; end
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    repeat (5) tick();
    total++;
    if (!ok || beat_q.size() - b != BEATS || done_cnt - d != 1) begin
      bad++; $display("FAIL rnd_count got done=%b beats=%0d dones=%0d want 1 %0d 1",
                      ok, beat_q.size() - b, done_cnt - d, BEATS);
    end
    for (int i = 0; i < BEATS && b + i < beat_q.size(); i++) begin
      total++;
      if (beat_q[b+i] !== exp_beat(i) || last_q[b+i] !== (i == BEATS-1)) begin
        bad++; $display("FAIL rnd_beat%0d got %h last=%b want %h", i, beat_q[b+i], last_q[b+i], exp_beat(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_run();
    test_backpressure();
    test_start_ignored();
    test_mid_reset();
    test_random_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
